// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard/flush sequencer.
//   PC_SEL_* : pc_sel codes driven to the PC mux
//   EXC_HANDLER : exception/interrupt handler entry address
//   TUSE_NONE : Tuse value meaning "source operand not read"
//   state_e : sequencer state codes (RUN / REDIR)
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0]  PC_SEL_SEQ  = 2'd0;  // PC+4 or branch target
  localparam logic [1:0]  PC_SEL_EXC  = 2'd1;  // exception handler
  localparam logic [1:0]  PC_SEL_EPC  = 2'd2;  // return from exception
  localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
  localparam logic [1:0]  TUSE_NONE   = 2'd3;

  typedef enum logic {
    StRun   = 1'b0,
    StRedir = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and pipeline-register controls between the datapath
// (master) and the hazard sequencer (slave).
//   D_* : operand info of the instruction in D
//   E_* / M_* : destination and result-timing info of instructions in E / M
//   M_exc, M_eret : redirect requests from stage M
//   stall .. state : controls returned by the sequencer
interface pipe_hazard_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic       D_md_use;
  logic [4:0] E_A3;
  logic [4:0] M_A3;
  logic       E_RFWr;
  logic       M_RFWr;
  logic [1:0] E_Tnew;
  logic [1:0] M_Tnew;
  logic       E_md_start;
  logic       E_md_div;
  logic       M_exc;
  logic       M_eret;

  logic       stall;
  logic       PC_en;
  logic       FD_en;
  logic       FD_clr;
  logic       DE_clr;
  logic       EM_clr;
  logic       MW_clr;
  logic       md_go;
  logic       md_busy;
  logic [1:0] pc_sel;
  logic       state;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use, E_A3, M_A3, E_RFWr, M_RFWr,
           E_Tnew, M_Tnew, E_md_start, E_md_div, M_exc, M_eret,
    input  stall, PC_en, FD_en, FD_clr, DE_clr, EM_clr, MW_clr, md_go, md_busy, pc_sel, state
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use, E_A3, M_A3, E_RFWr, M_RFWr,
           E_Tnew, M_Tnew, E_md_start, E_md_div, M_exc, M_eret,
    output stall, PC_en, FD_en, FD_clr, DE_clr, EM_clr, MW_clr, md_go, md_busy, pc_sel, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Multiply/divide unit occupancy countdown.
//   clk, reset : clock, synchronous active-high reset
//   go_i       : MDU operation accepted in E this cycle
//   div_i      : 1 = divide class (long), 0 = multiply class
//   busy_o     : countdown non-zero
module pipe_hazard_ctrl_md_busy_cnt #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic go_i,
  input  logic div_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // A new op restarts the count even if the previous one is still running.
    if (go_i) begin
      cnt_d = div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
//   clk, reset : clock, synchronous active-high reset
//   hz         : slave side of pipe_hazard_ctrl_if; stage status in, register controls out
// Stalls D on Tuse/Tnew register hazards and on MDU-busy, flushes F/D, D/E, E/M (and M/W for
// exceptions) when stage M redirects the PC, and spends one cycle in REDIR afterwards while
// the flushed bubble occupies M.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  state_e state_q;
  logic   redirect;
  logic   exc_take;
  logic   hz_rs, hz_rt, hz_md;
  logic   stall;
  logic   md_go;
  logic   md_busy;

  // Redirect requests are only legal in RUN; in REDIR M holds a bubble, so they are ignored.
  assign redirect = (state_q == StRun) & (hz.M_exc | hz.M_eret);
  assign exc_take = (state_q == StRun) & hz.M_exc;

  // A producer stalls the consumer only if its result arrives later than it is needed;
  // equal timing is covered by forwarding.
  assign hz_rs = (hz.D_rs != 5'd0) &
                 ((hz.E_RFWr & (hz.E_A3 == hz.D_rs) & (hz.E_Tnew > hz.D_Tuse_rs)) |
                  (hz.M_RFWr & (hz.M_A3 == hz.D_rs) & (hz.M_Tnew > hz.D_Tuse_rs)));
  assign hz_rt = (hz.D_rt != 5'd0) &
                 ((hz.E_RFWr & (hz.E_A3 == hz.D_rt) & (hz.E_Tnew > hz.D_Tuse_rt)) |
                  (hz.M_RFWr & (hz.M_A3 == hz.D_rt) & (hz.M_Tnew > hz.D_Tuse_rt)));
  assign hz_md = hz.D_md_use & (md_busy | hz.E_md_start);

  assign stall = (hz_rs | hz_rt | hz_md) & ~redirect;
  assign md_go = hz.E_md_start & ~redirect;

  pipe_hazard_ctrl_md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .go_i   (md_go),
    .div_i  (hz.E_md_div),
    .busy_o (md_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:   if (redirect) state_q <= StRedir;
        StRedir: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    hz.stall   = stall;
    hz.PC_en   = ~stall;
    hz.FD_en   = ~stall;
    hz.FD_clr  = redirect;
    hz.DE_clr  = redirect | stall;
    hz.EM_clr  = redirect;
    // An eret still retires through W; only a faulting instruction is squashed there.
    hz.MW_clr  = exc_take;
    hz.md_go   = md_go;
    hz.md_busy = md_busy;
    hz.state   = state_q;
    hz.pc_sel  = PC_SEL_SEQ;
    if (exc_take) begin
      hz.pc_sel = PC_SEL_EXC;
    end else if (redirect) begin
      hz.pc_sel = PC_SEL_EPC;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz_if ();

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: remaining MDU busy cycles and "one cycle after a redirect" flag.
  int md_left     = 0;
  bit in_redir    = 1'b0;
  bit model_valid = 1'b0;

  function automatic bit src_hazard(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0) return 1'b0;
    if (hz_if.E_RFWr && hz_if.E_A3 == r && int'(hz_if.E_Tnew) > int'(tuse)) return 1'b1;
    if (hz_if.M_RFWr && hz_if.M_A3 == r && int'(hz_if.M_Tnew) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_redirect();
    return !in_redir && (hz_if.M_exc || hz_if.M_eret);
  endfunction

  function automatic bit m_stall();
    bit need;
    need = src_hazard(hz_if.D_rs, hz_if.D_Tuse_rs) || src_hazard(hz_if.D_rt, hz_if.D_Tuse_rt) ||
           (hz_if.D_md_use && (md_left > 0 || hz_if.E_md_start));
    return need && !m_redirect();
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      md_left     <= 0;
      in_redir    <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      in_redir <= m_redirect();
      if (hz_if.E_md_start && !m_redirect()) md_left <= hz_if.E_md_div ? 10 : 5;
      else if (md_left > 0) md_left <= md_left - 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      bit s, r, e;
      s = m_stall();
      r = m_redirect();
      e = !in_redir && hz_if.M_exc;
      chk("m.stall",   int'(hz_if.stall),   int'(s));
      chk("m.PC_en",   int'(hz_if.PC_en),   int'(!s));
      chk("m.FD_en",   int'(hz_if.FD_en),   int'(!s));
      chk("m.FD_clr",  int'(hz_if.FD_clr),  int'(r));
      chk("m.DE_clr",  int'(hz_if.DE_clr),  int'(r || s));
      chk("m.EM_clr",  int'(hz_if.EM_clr),  int'(r));
      chk("m.MW_clr",  int'(hz_if.MW_clr),  int'(e));
      chk("m.md_go",   int'(hz_if.md_go),   int'(hz_if.E_md_start && !r));
      chk("m.md_busy", int'(hz_if.md_busy), int'(md_left > 0));
      chk("m.pc_sel",  int'(hz_if.pc_sel),  e ? 1 : (r ? 2 : 0));
      chk("m.state",   int'(hz_if.state),   int'(in_redir));
      if (!reset && in_redir) begin
        assert (!(hz_if.M_exc || hz_if.M_eret))
          else $error("redirect request while in REDIR");
      end
    end
  end

  task automatic idle();
    hz_if.D_rs = 5'd0;  hz_if.D_rt = 5'd0;
    hz_if.D_Tuse_rs = 2'd3; hz_if.D_Tuse_rt = 2'd3;
    hz_if.D_md_use = 1'b0;
    hz_if.E_A3 = 5'd0;  hz_if.M_A3 = 5'd0;
    hz_if.E_RFWr = 1'b0; hz_if.M_RFWr = 1'b0;
    hz_if.E_Tnew = 2'd0; hz_if.M_Tnew = 2'd0;
    hz_if.E_md_start = 1'b0; hz_if.E_md_div = 1'b0;
    hz_if.M_exc = 1'b0; hz_if.M_eret = 1'b0;
  endtask

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".stall"},   int'(hz_if.stall),   0);
    chk({tag, ".PC_en"},   int'(hz_if.PC_en),   1);
    chk({tag, ".FD_en"},   int'(hz_if.FD_en),   1);
    chk({tag, ".clr"},     int'({hz_if.FD_clr, hz_if.DE_clr, hz_if.EM_clr, hz_if.MW_clr}), 0);
    chk({tag, ".pc_sel"},  int'(hz_if.pc_sel),  0);
    chk({tag, ".md_busy"}, int'(hz_if.md_busy), 0);
    chk({tag, ".state"},   int'(hz_if.state),   0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    settle();
    chk_reset_outputs("rst");
    reset = 1'b0;

    // 1: lw in E, dependent add in D -> load-use stall, released when Tnew drops.
    step();
    hz_if.E_RFWr = 1'b1; hz_if.E_A3 = 5'd1; hz_if.E_Tnew = 2'd2;
    hz_if.D_rs = 5'd1; hz_if.D_Tuse_rs = 2'd1;
    settle();
    chk("t1.stall", int'(hz_if.stall), 1);
    chk("t1.PC_en", int'(hz_if.PC_en), 0);
    chk("t1.DE_clr", int'(hz_if.DE_clr), 1);
    step();
    hz_if.E_Tnew = 2'd1;
    settle();
    chk("t1.release", int'(hz_if.stall), 0);

    // 2: register 0 never hazards.
    step();
    idle();
    hz_if.E_RFWr = 1'b1; hz_if.E_A3 = 5'd0; hz_if.E_Tnew = 2'd2;
    hz_if.D_rs = 5'd0; hz_if.D_Tuse_rs = 2'd0;
    settle();
    chk("t2.r0", int'(hz_if.stall), 0);

    // rt hazard from M.
    step();
    idle();
    hz_if.M_RFWr = 1'b1; hz_if.M_A3 = 5'd5; hz_if.M_Tnew = 2'd1;
    hz_if.D_rt = 5'd5; hz_if.D_Tuse_rt = 2'd0;
    settle();
    chk("t2.m_rt", int'(hz_if.stall), 1);

    // 3: div occupies the MDU for exactly 10 cycles; mflo stalls throughout.
    step();
    idle();
    hz_if.E_md_start = 1'b1; hz_if.E_md_div = 1'b1;
    settle();
    chk("t3.go", int'(hz_if.md_go), 1);
    chk("t3.busy0", int'(hz_if.md_busy), 0);
    for (int i = 0; i < 10; i++) begin
      step();
      idle();
      hz_if.D_md_use = 1'b1;
      settle();
      chk("t3.busy", int'(hz_if.md_busy), 1);
      chk("t3.stall", int'(hz_if.stall), 1);
    end
    step();
    settle();
    chk("t3.done", int'(hz_if.md_busy), 0);
    chk("t3.free", int'(hz_if.stall), 0);

    // mult: 5 cycles.
    step();
    idle();
    hz_if.E_md_start = 1'b1;
    repeat (5) begin
      step();
      idle();
      settle();
      chk("t3.mult", int'(hz_if.md_busy), 1);
    end
    step();
    settle();
    chk("t3.multdone", int'(hz_if.md_busy), 0);

    // 4: exception masks a load-use stall and cancels the MDU op in E.
    step();
    idle();
    hz_if.E_RFWr = 1'b1; hz_if.E_A3 = 5'd3; hz_if.E_Tnew = 2'd2;
    hz_if.D_rs = 5'd3; hz_if.D_Tuse_rs = 2'd0;
    hz_if.E_md_start = 1'b1; hz_if.M_exc = 1'b1;
    settle();
    chk("t4.stall", int'(hz_if.stall), 0);
    chk("t4.clr", int'({hz_if.FD_clr, hz_if.DE_clr, hz_if.EM_clr, hz_if.MW_clr}), 15);
    chk("t4.pc_sel", int'(hz_if.pc_sel), 1);
    chk("t4.md_go", int'(hz_if.md_go), 0);
    chk("t4.PC_en", int'(hz_if.PC_en), 1);
    step();
    hz_if.M_exc = 1'b0; hz_if.E_md_start = 1'b0;
    settle();
    chk("t4.redir", int'(hz_if.state), 1);
    chk("t4.redir_stall", int'(hz_if.stall), 1);
    chk("t4.no_md", int'(hz_if.md_busy), 0);

    // eret alone: EPC, write-back not squashed.
    step();
    idle();
    hz_if.M_eret = 1'b1;
    settle();
    chk("eret.pc_sel", int'(hz_if.pc_sel), 2);
    chk("eret.MW_clr", int'(hz_if.MW_clr), 0);
    chk("eret.EM_clr", int'(hz_if.EM_clr), 1);
    step();
    idle();

    // 5: exc + eret together -> exception wins, one REDIR cycle.
    step();
    hz_if.M_exc = 1'b1; hz_if.M_eret = 1'b1;
    settle();
    chk("t5.pc_sel", int'(hz_if.pc_sel), 1);
    chk("t5.MW_clr", int'(hz_if.MW_clr), 1);
    step();
    idle();
    settle();
    chk("t5.redir", int'(hz_if.state), 1);
    step();
    settle();
    chk("t5.run", int'(hz_if.state), 0);

    // 6: reset with countdown at 7 and active requests.
    step();
    hz_if.E_md_start = 1'b1; hz_if.E_md_div = 1'b1;
    step();
    idle();
    repeat (3) step();
    reset = 1'b1;
    hz_if.E_md_start = 1'b1; hz_if.M_exc = 1'b1;
    settle();
    chk("t6.busy7", int'(hz_if.md_busy), 1);
    step();
    idle();
    reset = 1'b0;
    settle();
    chk_reset_outputs("t6");

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
